// File: rtl/core_pkg.sv
// Core-wide widths plus the CDB arbitration types: slot count, source indices, broadcast packet.
// Pure declarations; no logic, no latency.
package core_pkg;

  localparam int XLEN        = 32;
  localparam int LOG2_PREGS  = 6;
  localparam int ROB_ENTRIES = 32;
  localparam int ROB_W       = $clog2(ROB_ENTRIES);

  localparam int CDB_PORTS    = 2;
  localparam int CDB_SRC_ALU0 = 0;
  localparam int CDB_SRC_ALU1 = 1;
  localparam int CDB_SRC_LSU  = 2;
  localparam int CDB_SRC_BRU  = 3;

  typedef struct packed {
    logic [LOG2_PREGS-1:0] tag;
    logic [XLEN-1:0]       value;
    logic [ROB_W-1:0]      rob_idx;
  } cdb_pkt_t;

endpackage

// File: rtl/cdb_pick2.sv
// Picks the first two requesters in rotated priority order starting at 'start'.
// Purely combinational; returns one-hot grants per slot and slot-valid bits.
module cdb_pick2 #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] start,
  output logic [N-1:0]  gnt0,
  output logic [N-1:0]  gnt1,
  output logic          vld0,
  output logic          vld1
);

  always_comb begin
    int idx;
    idx  = 0;
    gnt0 = '0;
    gnt1 = '0;
    vld0 = 1'b0;
    vld1 = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(start) + k) % N;
      if (req[idx]) begin
        if (!vld0) begin
          gnt0[idx] = 1'b1;
          vld0      = 1'b1;
        end else if (!vld1) begin
          gnt1[idx] = 1'b1;
          vld1      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Two-slot CDB arbiter over per-source one-entry holds; src_valid to cdb_valid takes at least 2 edges.
// Sources stall while their hold is occupied and ungranted. Define CDB_RR_ARB_EN for round-robin, else fixed priority.
module cdb_arbiter
  import core_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int XLEN    = core_pkg::XLEN,
  parameter int PHYS_W  = core_pkg::LOG2_PREGS,
  parameter int ROB_W   = $clog2(core_pkg::ROB_ENTRIES)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 flush_pipeline,
  input  logic [NUM_SRC-1:0]                   src_valid,
  output logic [NUM_SRC-1:0]                   src_ready,
  input  logic [NUM_SRC-1:0][PHYS_W-1:0]       src_tag,
  input  logic [NUM_SRC-1:0][XLEN-1:0]         src_value,
  input  logic [NUM_SRC-1:0][ROB_W-1:0]        src_rob_idx,
  output logic [CDB_PORTS-1:0]                 cdb_valid,
  output logic [CDB_PORTS-1:0][PHYS_W-1:0]     cdb_tag,
  output logic [CDB_PORTS-1:0][XLEN-1:0]       cdb_value,
  output logic [CDB_PORTS-1:0][ROB_W-1:0]      cdb_rob_idx
);

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0] hold_valid;
  cdb_pkt_t           hold_pkt [NUM_SRC];
  logic [NUM_SRC-1:0] gnt0, gnt1, grant;
  logic               slot_vld0, slot_vld1;
  logic [PTR_W-1:0]   start_ptr;
  cdb_pkt_t           slot_pkt [CDB_PORTS];

  cdb_pick2 #(
    .N  (NUM_SRC),
    .PW (PTR_W)
  ) u_pick2 (
    .req   (hold_valid),
    .start (start_ptr),
    .gnt0  (gnt0),
    .gnt1  (gnt1),
    .vld0  (slot_vld0),
    .vld1  (slot_vld1)
  );

  assign grant     = gnt0 | gnt1;
  assign src_ready = {NUM_SRC{!reset && !flush_pipeline}} & (~hold_valid | grant);

`ifdef CDB_RR_ARB_EN
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] last_idx;

  // The last granted source is slot1's winner when present, otherwise slot0's.
  always_comb begin
    last_idx = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (slot_vld1 ? gnt1[i] : gnt0[i]) last_idx = PTR_W'(i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (!flush_pipeline && slot_vld0) begin
      rr_ptr <= (int'(last_idx) == NUM_SRC - 1) ? '0 : last_idx + 1'b1;
    end
  end

  assign start_ptr = rr_ptr;
`else
  assign start_ptr = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_valid <= '0;
      for (int i = 0; i < NUM_SRC; i++) hold_pkt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (flush_pipeline) begin
          hold_valid[i] <= 1'b0;
        end else if (src_valid[i] && src_ready[i]) begin
          hold_valid[i]       <= 1'b1;
          hold_pkt[i].tag     <= src_tag[i];
          hold_pkt[i].value   <= src_value[i];
          hold_pkt[i].rob_idx <= src_rob_idx[i];
        end else if (grant[i]) begin
          hold_valid[i] <= 1'b0;
        end
      end
    end
  end

  // One-hot grants let an OR-reduction act as the slot mux; ungranted slots fall out as zero.
  always_comb begin
    slot_pkt[0] = '0;
    slot_pkt[1] = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (gnt0[i]) slot_pkt[0] = cdb_pkt_t'(slot_pkt[0] | hold_pkt[i]);
      if (gnt1[i]) slot_pkt[1] = cdb_pkt_t'(slot_pkt[1] | hold_pkt[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cdb_valid   <= '0;
      cdb_tag     <= '0;
      cdb_value   <= '0;
      cdb_rob_idx <= '0;
    end else if (flush_pipeline) begin
      cdb_valid   <= '0;
      cdb_tag     <= '0;
      cdb_value   <= '0;
      cdb_rob_idx <= '0;
    end else begin
      cdb_valid <= {slot_vld1, slot_vld0};
      for (int s = 0; s < CDB_PORTS; s++) begin
        cdb_tag[s]     <= slot_pkt[s].tag;
        cdb_value[s]   <= slot_pkt[s].value;
        cdb_rob_idx[s] <= slot_pkt[s].rob_idx;
      end
    end
  end

endmodule
